// File: rtl/tick_scheduler_if.sv
// ----------------------------------------------------------------------------
// tick_scheduler_if
//  Configuration write port of the tick scheduler (valid/ready handshake).
//  master : configuration source (drives valid/addr/en/period)
//  slave  : tick_scheduler (drives ready/err)
//  Signals:
//   cfg_valid   write request
//   cfg_ready   pending slot free; write accepted when valid && ready
//   cfg_addr    target channel            [CH_AW-1:0]
//   cfg_en      channel enable
//   cfg_period  period in base ticks      [PERIOD_W-1:0] (0 = disabled)
//   cfg_err     1-cycle pulse: accepted write addressed a missing channel
// ----------------------------------------------------------------------------
interface tick_scheduler_if #(
    parameter int CH_AW    = 2,
    parameter int PERIOD_W = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_AW-1:0]    cfg_addr;
    logic                cfg_en;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_addr, cfg_en, cfg_period,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_en, cfg_period,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/tick_scheduler.sv
// ----------------------------------------------------------------------------
// tick_scheduler
//  Shared timebase: a prescaler divides clk into a base tick; NUM_CH channels
//  count base ticks up to a programmable period and emit a 1-cycle tick pulse
//  plus a square wave that toggles on every tick. Channels are configured
//  through a single-slot valid/ready write port; a pending write is applied
//  on the next prescaler wrap so channel phase always changes on a tick edge.
//
//  Optional feature macro: TICK_SCHED_SYNC_EN
//   defined   -> sync_start input restarts prescaler and all channel phases
//   undefined -> no sync_start port; phase alignment only through rst
//
//  Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   sync_start  (TICK_SCHED_SYNC_EN only) phase restart strobe
//   cfg         tick_scheduler_if.slave configuration write port
//   base_tick   1-cycle pulse every PRESCALE clocks
//   ch_tick     per-channel 1-cycle tick pulse     [NUM_CH-1:0]
//   ch_level    per-channel square wave            [NUM_CH-1:0]
// ----------------------------------------------------------------------------
module tick_scheduler #(
    parameter int PRESCALE = 100000,
    parameter int NUM_CH   = 4,
    parameter int CH_AW    = 2,
    parameter int PERIOD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TICK_SCHED_SYNC_EN
    input  logic                 sync_start,
`endif
    tick_scheduler_if.slave      cfg,
    output logic                 base_tick,
    output logic [NUM_CH-1:0]    ch_tick,
    output logic [NUM_CH-1:0]    ch_level
);

    localparam int               PRE_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CH_AW:0]   NUM_CH_W = (CH_AW + 1)'(NUM_CH);

    logic [PRE_W-1:0]    pre_cnt_reg;
    logic                base_tick_reg;
    logic                pending_reg;
    logic                ready_reg;
    logic                err_reg;
    logic [CH_AW-1:0]    pend_addr_reg;
    logic                pend_en_reg;
    logic [PERIOD_W-1:0] pend_period_reg;

    logic wrap;
    logic sync_hit;
    logic accept;
    logic addr_oor;
    logic apply;

`ifdef TICK_SCHED_SYNC_EN
    assign sync_hit = sync_start;
`else
    assign sync_hit = 1'b0;
`endif

    assign wrap     = (pre_cnt_reg == PRE_LAST);
    assign accept   = cfg.cfg_valid && ready_reg;
    // Extra MSB so the compare stays meaningful when 2**CH_AW == NUM_CH.
    assign addr_oor = ({1'b0, cfg.cfg_addr} >= NUM_CH_W);
    // The pending slot is only consumed on an edge where it was already full,
    // so a write accepted on a wrap edge waits for the following wrap.
    assign apply    = pending_reg && (wrap || sync_hit);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg   <= '0;
            base_tick_reg <= 1'b0;
        end else if (sync_hit) begin
            pre_cnt_reg   <= '0;
            base_tick_reg <= 1'b0;
        end else if (wrap) begin
            pre_cnt_reg   <= '0;
            base_tick_reg <= 1'b1;
        end else begin
            pre_cnt_reg   <= pre_cnt_reg + 1'b1;
            base_tick_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Configuration slot. Out-of-range writes are accepted but never
    // occupy the slot, so ready stays high for them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg     <= 1'b0;
            ready_reg       <= 1'b1;
            err_reg         <= 1'b0;
            pend_addr_reg   <= '0;
            pend_en_reg     <= 1'b0;
            pend_period_reg <= '0;
        end else begin
            err_reg <= accept && addr_oor;
            if (accept && !addr_oor) begin
                pending_reg     <= 1'b1;
                ready_reg       <= 1'b0;
                pend_addr_reg   <= cfg.cfg_addr;
                pend_en_reg     <= cfg.cfg_en;
                pend_period_reg <= cfg.cfg_period;
            end else if (apply) begin
                pending_reg <= 1'b0;
                ready_reg   <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready = ready_reg;
    assign cfg.cfg_err   = err_reg;
    assign base_tick     = base_tick_reg;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                en_reg;
            logic [PERIOD_W-1:0] period_reg;
            logic [PERIOD_W-1:0] cnt_reg;
            logic                tick_reg;
            logic                level_reg;
            logic                apply_hit;

            assign apply_hit = apply && (pend_addr_reg == CH_AW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    en_reg     <= 1'b0;
                    period_reg <= '0;
                    cnt_reg    <= '0;
                    tick_reg   <= 1'b0;
                    level_reg  <= 1'b0;
                end else begin
                    tick_reg <= 1'b0;
                    if (apply_hit) begin
                        // New settings restart the phase; no tick on this edge.
                        en_reg     <= pend_en_reg;
                        period_reg <= pend_period_reg;
                        cnt_reg    <= '0;
                        level_reg  <= 1'b0;
                    end else if (sync_hit || !en_reg || (period_reg == '0)) begin
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                    end else if (wrap) begin
                        if (cnt_reg == period_reg - 1'b1) begin
                            cnt_reg   <= '0;
                            tick_reg  <= 1'b1;
                            level_reg <= ~level_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign ch_tick[gi]  = tick_reg;
            assign ch_level[gi] = level_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tick_scheduler
//  Bench for tick_scheduler with PRESCALE=4, NUM_CH=4, CH_AW=3.
//  A cycle model predicts every output for each clock; predictions are queued
//  when inputs are driven and popped/compared one cycle later. A table of
//  configuration writes drives the main sequence; hand-written sequences cover
//  reset with a write pending and (TICK_SCHED_SYNC_EN) the sync restart.
// ----------------------------------------------------------------------------
module tb_tick_scheduler;

    localparam int PRESCALE = 4;
    localparam int NUM_CH   = 4;
    localparam int CH_AW    = 3;
    localparam int PERIOD_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_start = 1'b0;
    logic                base_tick;
    logic [NUM_CH-1:0]   ch_tick;
    logic [NUM_CH-1:0]   ch_level;

    tick_scheduler_if #(.CH_AW(CH_AW), .PERIOD_W(PERIOD_W)) cfg_if ();

    tick_scheduler #(
        .PRESCALE (PRESCALE),
        .NUM_CH   (NUM_CH),
        .CH_AW    (CH_AW),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef TICK_SCHED_SYNC_EN
        .sync_start (sync_start),
`endif
        .cfg        (cfg_if.slave),
        .base_tick  (base_tick),
        .ch_tick    (ch_tick),
        .ch_level   (ch_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              base;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] lvl;
        logic              ready;
        logic              err;
    } exp_t;

    typedef struct {
        logic [CH_AW-1:0]    addr;
        logic                en;
        logic [PERIOD_W-1:0] period;
        int                  hold;     // idle cycles after the write
        logic                exp_err;  // cfg_err expected the cycle after accept
    } vec_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // model state
    int   m_pre;
    bit   m_pend;
    int   m_paddr;
    bit   m_pen;
    int   m_pper;
    bit   m_en  [NUM_CH];
    int   m_per [NUM_CH];
    int   m_cnt [NUM_CH];
    bit   m_tick[NUM_CH];
    bit   m_lvl [NUM_CH];
    bit   m_base, m_ready, m_err;

    // ch_level[0] period measurement
    int   lvl0_last_rise = -1;
    int   lvl0_per       = -1;
    logic lvl0_prev      = 1'b0;

    task automatic model_next(output exp_t e);
        bit wrap, acc, oor, syn, app;
        if (rst) begin
            m_pre = 0; m_pend = 0; m_paddr = 0; m_pen = 0; m_pper = 0;
            m_base = 0; m_ready = 1; m_err = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_en[k] = 0; m_per[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_lvl[k] = 0;
            end
        end else begin
            syn = 0;
`ifdef TICK_SCHED_SYNC_EN
            syn = sync_start;
`endif
            wrap = (m_pre == PRESCALE - 1);
            acc  = cfg_if.cfg_valid && m_ready;
            oor  = int'(cfg_if.cfg_addr) >= NUM_CH;
            app  = m_pend && (wrap || syn);
            for (int k = 0; k < NUM_CH; k++) begin
                m_tick[k] = 0;
                if (app && m_paddr == k) begin
                    m_en[k] = m_pen; m_per[k] = m_pper; m_cnt[k] = 0; m_lvl[k] = 0;
                end else if (syn || !m_en[k] || m_per[k] == 0) begin
                    m_cnt[k] = 0; m_lvl[k] = 0;
                end else if (wrap) begin
                    if (m_cnt[k] + 1 == m_per[k]) begin
                        m_cnt[k] = 0; m_tick[k] = 1; m_lvl[k] = !m_lvl[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            m_base = wrap && !syn;
            m_pre  = (wrap || syn) ? 0 : m_pre + 1;
            m_err  = acc && oor;
            if (app) begin
                m_pend = 0; m_ready = 1;
            end
            if (acc && !oor) begin
                m_pend = 1; m_ready = 0;
                m_paddr = int'(cfg_if.cfg_addr); m_pen = cfg_if.cfg_en;
                m_pper = int'(cfg_if.cfg_period);
            end
        end
        e.base  = m_base;
        e.ready = m_ready;
        e.err   = m_err;
        for (int k = 0; k < NUM_CH; k++) begin
            e.tick[k] = m_tick[k];
            e.lvl[k]  = m_lvl[k];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // One clock: predict, advance, compare. Prints one line per cycle.
    task automatic step();
        exp_t e;
        model_next(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        chk("base_tick", 32'(base_tick), 32'(e.base));
        chk("ch_tick",   32'(ch_tick),   32'(e.tick));
        chk("ch_level",  32'(ch_level),  32'(e.lvl));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e.ready));
        chk("cfg_err",   32'(cfg_if.cfg_err),   32'(e.err));
        if (ch_level[0] && !lvl0_prev) begin
            if (lvl0_last_rise >= 0) lvl0_per = cyc - lvl0_last_rise;
            lvl0_last_rise = cyc;
        end
        lvl0_prev = ch_level[0];
        $display("cyc=%0d rst=%0b v=%0b rdy=%0b err=%0b base=%0b tick=%b lvl=%b",
                 cyc, rst, cfg_if.cfg_valid, cfg_if.cfg_ready, cfg_if.cfg_err,
                 base_tick, ch_tick, ch_level);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [CH_AW-1:0] a, input logic en,
                            input logic [PERIOD_W-1:0] p, output bit ok);
        bit was_rdy;
        ok = 0;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_addr   = a;
        cfg_if.cfg_en     = en;
        cfg_if.cfg_period = p;
        for (int n = 0; n < 64 && !ok; n++) begin
            was_rdy = cfg_if.cfg_ready;
            step();
            if (was_rdy) ok = 1;
        end
        cfg_if.cfg_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%0d got=no_accept want=accept", a);
        end
    endtask

    vec_t vecs[6];
    int   bt_log[$];
    int   n_t3;
    int   n_base, n_tick;
    bit   ok, seen;

    initial begin
        // write table: {addr, en, period, hold, exp_err}
        vecs[0] = '{addr: 3'd0, en: 1'b1, period: 16'd3, hold: 50, exp_err: 1'b0};
        vecs[1] = '{addr: 3'd1, en: 1'b1, period: 16'd1, hold: 0,  exp_err: 1'b0};
        vecs[2] = '{addr: 3'd2, en: 1'b1, period: 16'd2, hold: 40, exp_err: 1'b0};
        vecs[3] = '{addr: 3'd5, en: 1'b1, period: 16'd7, hold: 10, exp_err: 1'b1};
        vecs[4] = '{addr: 3'd0, en: 1'b0, period: 16'd3, hold: 20, exp_err: 1'b0};
        vecs[5] = '{addr: 3'd0, en: 1'b1, period: 16'd3, hold: 30, exp_err: 1'b0};

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_addr   = '0;
        cfg_if.cfg_en     = 1'b0;
        cfg_if.cfg_period = '0;

        // Reset and release: base_tick at 4, 8, 12 cycles after rst falls.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (base_tick) bt_log.push_back(i);
        end
        chk("base_tick_count", 32'(bt_log.size()), 32'd3);
        if (bt_log.size() == 3) begin
            chk("base_tick_t0", 32'(bt_log[0]), 32'd4);
            chk("base_tick_t1", 32'(bt_log[1]), 32'd8);
            chk("base_tick_t2", 32'(bt_log[2]), 32'd12);
        end

        // Table-driven configuration writes.
        for (int v = 0; v < 6; v++) begin
            do_write(vecs[v].addr, vecs[v].en, vecs[v].period, ok);
            if (ok) begin
                chk("accept_err",   32'(cfg_if.cfg_err),   32'(vecs[v].exp_err));
                chk("accept_ready", 32'(cfg_if.cfg_ready), 32'(vecs[v].exp_err));
            end
            idle(vecs[v].hold);
            if (v == 0) chk("ch0_level_period", 32'(lvl0_per), 32'd24);
        end

        // Reset mid-count with ch0 running and a write pending.
        do_write(3'd3, 1'b1, 16'd2, ok);
        chk("pending_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_ready",   32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_level",   32'(ch_level), 32'd0);
        chk("rst_tick",    32'(ch_tick),  32'd0);
        chk("rst_base",    32'(base_tick), 32'd0);
        rst = 1'b0;
        n_t3 = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ch_tick[3]) n_t3++;
        end
        chk("pending_lost", 32'(n_t3), 32'd0);

`ifdef TICK_SCHED_SYNC_EN
        // Sync restart with ch0 mid-period.
        do_write(3'd0, 1'b1, 16'd3, ok);
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (ch_tick[0]) seen = 1;
        end
        chk("sync_pre_tick_seen", 32'(seen), 32'd1);
        idle(6);
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
        chk("sync_base_clear", 32'(base_tick), 32'd0);
        n_base = -1;
        n_tick = -1;
        for (int i = 1; i <= 40 && n_tick < 0; i++) begin
            step();
            if (base_tick && n_base < 0) n_base = i;
            if (ch_tick[0] && n_tick < 0) n_tick = i;
        end
        chk("sync_next_base", 32'(n_base), 32'd4);
        chk("sync_first_tick", 32'(n_tick), 32'd12);
`endif

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
